tlb_op_unit: RTL and testbench
==============================

# tlb_op_unit

Memory-stage TLB engine for the MIPS pipeline. It owns a fully associative 16-entry joint TLB and executes the TLBP, TLBR and TLBWI operations that the decode controller flags on `tlb_type`. It stalls the pipeline while an operation is in flight and returns results to CP0 through write-enable/value pairs. It also provides one combinational translation port for the data path.

## Interface
- `ENTRIES`, 16: TLB entries; must be a power of two.
- `IDXW`, 4: index width, log2(ENTRIES).
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `tlb_type`  in  2  M-stage TLB op: 00 none, 01 TLBP, 10 TLBR, 11 TLBWI.
- `flush`  in  1  M-stage flush (flushM).
- `adv`  in  1  M→W advance this cycle (~stallM from hazard unit).
- `cp0_entryhi`  in  32  VPN2[31:13], ASID[7:0].
- `cp0_entrylo0`, `cp0_entrylo1`  in  32 each  PFN[25:6], C[5:3], D[2], V[1], G[0].
- `cp0_index`  in  32  Index[IDXW-1:0] used.
- `stall`  out  1  request pipeline stall.
- `index_we`, `index_val`  out  1/32  P[31], Index[IDXW-1:0], others 0.
- `entryhi_we`, `entryhi_val`  out  1/32.
- `entrylo0_we`, `entrylo0_val`, `entrylo1_we`, `entrylo1_val`  out  1/32 each.
- `lk_vaddr`  in  32  data virtual address.
- `lk_hit`, `lk_v`, `lk_d`  out  1 each; `lk_paddr`  out  32.

## Operation
- Entry fields: VPN2, ASID, G, and per even/odd page PFN, C, D, V. Page size is fixed at 4 KB; PageMask is not supported.
- FSM states: IDLE, PROBE, READ, WRITE, DONE.
- IDLE: when `tlb_type`≠00 and `flush`=0, the unit snapshots `cp0_entryhi`, `cp0_index`, lo0 and lo1. It then moves to PROBE, READ or WRITE according to `tlb_type`.
- PROBE: compares the snapshot against every entry using the registered compare vector. An entry matches when VPN2 is equal and (G=1 or ASID is equal).
  - Hit: `index_val` = {0, lowest matching index}.
  - Miss: `index_val` = 0x8000_0000.
  - `index_we` pulses. Next state is DONE.
- READ: reads entry[index]. Pulses `entryhi_we`, `entrylo0_we` and `entrylo1_we`. Each EntryLo G field returns the stored G. Next state is DONE.
- WRITE: entry[index] ← snapshot. The stored G is lo0.G & lo1.G. The array updates on the edge that ends WRITE. Next state is DONE.
- DONE: `stall`=0. The unit stays in DONE until `adv`=1 or `flush`=1, then goes to IDLE. This prevents re-issuing the same instruction while M is held for another reason.
- `flush`=1 in PROBE, READ or WRITE: the unit goes to IDLE and suppresses all `*_we` outputs and the array write in that cycle.
- `stall` = (IDLE & `tlb_type`≠00 & ~`flush`) | PROBE | READ | WRITE.
- Lookup port (combinational):
  - `lk_vaddr[12]` selects the odd or even page. ASID comes from live `cp0_entryhi`.
  - `lk_paddr` = {PFN[19:0], `lk_vaddr[11:0]`}.
  - On a miss, `lk_hit`, `lk_v`, `lk_d` and `lk_paddr` are all 0.
  - Multiple hits resolve to the lowest index.
- Index out of range cannot occur because Index is truncated to IDXW.

## Timing
- Reset: state is IDLE, and all entries have V0=V1=G=0, VPN2=0, ASID=0.
- Reset: every output is 0 (`stall`, all `*_we`, all `*_val`, `lk_*`).
- Every op takes 2 stall cycles (accept cycle plus op cycle). The `*_we` pulse lasts exactly 1 cycle, in the op cycle.
- The CP0 write lands on the edge ending the op cycle. The array write for TLBWI lands on that same edge.
- A TLBP in the cycle immediately after a TLBWI completes sees the new entry.
- `tlb_type` is stable while `stall`=1, because the controller's M register is held by stallM.
- A reset asserted mid-op aborts the op on that edge with no CP0 or array write.

## Structure
- The shared header `defines.h` holds:
  - `TLB_OP_NONE`/`TLBP`/`TLBR`/`TLBWI` encodings.
  - EntryHi/EntryLo field bit positions.
  - FSM state encodings.
- Sub-module `tlb_array` holds the entry storage, the write port, one indexed read port, the ENTRIES-wide compare vector and the lowest-index priority encoder. It is used by both the probe path and the lookup path.
- `tlb_op_unit` contains the FSM, the snapshot registers and the CP0 output muxing.

## Test plan
- TLBWI with index=3, EntryHi=0x0040_2005, lo0=0x0000_1047 (PFN 0x41, D V G), lo1=0x0000_1087 → 2 stall cycles. Then lookup of vaddr 0x0040_2ABC → hit, paddr 0x0004_1ABC, d=1, v=1.
- TLBP with EntryHi=0x0040_2005 after the above → `index_we` pulse, `index_val`=0x0000_0003. TLBP with EntryHi=0x1234_4005 → `index_val`=0x8000_0000.
- TLBR with index=3 → `entryhi_val`=0x0040_2005, `entrylo0_val`=0x0000_1047, all three `*_we` high for 1 cycle.
- Write a non-global entry with ASID 5, then probe with ASID 6 → miss. Rewrite with G on both lo registers, probe with ASID 6 → hit.
- Assert `flush` in the WRITE cycle → no array change and no `*_we`. A following TLBR returns the old contents.
- Hold `adv`=0 for 4 cycles in DONE with `tlb_type`=TLBP → exactly one `index_we` pulse and `stall`=0 throughout DONE. Assert `rst`=0 in PROBE → IDLE, no write.

Source files
------------

// File: rtl/tlb_op_unit_pkg.sv
// Shared encodings, field positions and the TLB entry layout for the memory-stage TLB engine.
package tlb_op_unit_pkg;

  typedef enum logic [1:0] {
    TLB_OP_NONE  = 2'b00,
    TLB_OP_TLBP  = 2'b01,
    TLB_OP_TLBR  = 2'b10,
    TLB_OP_TLBWI = 2'b11
  } tlb_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROBE = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } tlb_state_e;

  localparam int EHI_VPN2_LSB = 13;
  localparam int ASID_W       = 8;
  localparam int LO_PFN_LSB   = 6;
  localparam int LO_C_LSB     = 3;
  localparam int LO_D         = 2;
  localparam int LO_V         = 1;
  localparam int LO_G         = 0;

  typedef struct packed {
    logic [18:0]       vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [19:0]       pfn0;
    logic [2:0]        c0;
    logic              d0;
    logic              v0;
    logic [19:0]       pfn1;
    logic [2:0]        c1;
    logic              d1;
    logic              v1;
  } tlb_entry_t;

  function automatic logic entry_match(input tlb_entry_t e, input logic [18:0] vpn2,
                                       input logic [ASID_W-1:0] asid);
    return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
  endfunction

endpackage

// File: rtl/tlb_op_unit_if.sv
// Pipeline/CP0 side bundle of the TLB engine: op request, CP0 result pairs and lookup port.
interface tlb_op_unit_if;
  logic [1:0]  tlb_type;
  logic        flush;
  logic        adv;
  logic [31:0] cp0_entryhi;
  logic [31:0] cp0_entrylo0;
  logic [31:0] cp0_entrylo1;
  logic [31:0] cp0_index;
  logic        stall;
  logic        index_we;
  logic [31:0] index_val;
  logic        entryhi_we;
  logic [31:0] entryhi_val;
  logic        entrylo0_we;
  logic [31:0] entrylo0_val;
  logic        entrylo1_we;
  logic [31:0] entrylo1_val;
  logic [31:0] lk_vaddr;
  logic        lk_hit;
  logic        lk_v;
  logic        lk_d;
  logic [31:0] lk_paddr;

  modport master (
    output tlb_type, flush, adv, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index, lk_vaddr,
    input  stall, index_we, index_val, entryhi_we, entryhi_val, entrylo0_we, entrylo0_val,
           entrylo1_we, entrylo1_val, lk_hit, lk_v, lk_d, lk_paddr
  );

  modport slave (
    input  tlb_type, flush, adv, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index, lk_vaddr,
    output stall, index_we, index_val, entryhi_we, entryhi_val, entrylo0_we, entrylo0_val,
           entrylo1_we, entrylo1_val, lk_hit, lk_v, lk_d, lk_paddr
  );
endinterface

// File: rtl/tlb_op_unit_tlb_array.sv
// Fully associative entry storage with one write port, one indexed read port and two
// compare/priority-encode paths (probe snapshot and live data-path lookup).
module tlb_array
  import tlb_op_unit_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDXW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDXW-1:0]   widx,
  input  tlb_entry_t        wentry,
  input  logic [IDXW-1:0]   ridx,
  output tlb_entry_t        rentry,
  input  logic [18:0]       pr_vpn2,
  input  logic [ASID_W-1:0] pr_asid,
  output logic              pr_hit,
  output logic [IDXW-1:0]   pr_idx,
  input  logic [19:0]       lk_vpn,
  input  logic [ASID_W-1:0] lk_asid,
  output logic              lk_hit,
  output logic              lk_v,
  output logic              lk_d,
  output logic [19:0]       lk_pfn
);

  tlb_entry_t         mem_q [ENTRIES];
  tlb_entry_t         mem_d [ENTRIES];
  logic [ENTRIES-1:0] pr_vec;
  logic [ENTRIES-1:0] lk_vec;
  logic [IDXW-1:0]    lk_idx;
  tlb_entry_t         lk_e;

  function automatic logic [IDXW-1:0] lowest(input logic [ENTRIES-1:0] v);
    lowest = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (v[i]) lowest = IDXW'(i);
    end
  endfunction

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[widx] = wentry;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      mem_q[i] <= rst ? mem_d[i] : '0;
    end
  end

  // Entries with no valid page never translate, so a cleared array cannot alias address 0.
  always_comb begin
    pr_vec = '0;
    lk_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      pr_vec[i] = entry_match(mem_q[i], pr_vpn2, pr_asid);
      lk_vec[i] = entry_match(mem_q[i], lk_vpn[19:1], lk_asid) && (mem_q[i].v0 || mem_q[i].v1);
    end
  end

  assign pr_hit = |pr_vec;
  assign pr_idx = lowest(pr_vec);
  assign rentry = mem_q[ridx];
  assign lk_hit = |lk_vec;
  assign lk_idx = lowest(lk_vec);
  assign lk_e   = mem_q[lk_idx];

  always_comb begin
    lk_v   = 1'b0;
    lk_d   = 1'b0;
    lk_pfn = '0;
    if (lk_hit) begin
      lk_v   = lk_vec[lk_idx] && (lk_vpn[0] ? lk_e.v1 : lk_e.v0);
      lk_d   = lk_vpn[0] ? lk_e.d1 : lk_e.d0;
      lk_pfn = lk_vpn[0] ? lk_e.pfn1 : lk_e.pfn0;
    end
  end

endmodule

// File: rtl/tlb_op_unit.sv
// Memory-stage TLB engine: TLBP/TLBR/TLBWI sequencing, CP0 snapshot and result muxing,
// plus a combinational translation port.
module tlb_op_unit
  import tlb_op_unit_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDXW    = 4
) (
  input logic          clk,
  input logic          rst,
  tlb_op_unit_if.slave bus
);

  tlb_state_e      state_q, state_d;
  logic [31:0]     ehi_q, ehi_d, lo0_q, lo0_d, lo1_q, lo1_d;
  logic [IDXW-1:0] idx_q, idx_d;
  tlb_op_e         op;
  logic            accept, op_ok, arr_we, rd_we, pr_hit, lk_hit;
  logic [IDXW-1:0] pr_idx;
  logic [19:0]     lk_pfn;
  tlb_entry_t      wentry, rentry;
  logic            unused_bits;

  assign op     = tlb_op_e'(bus.tlb_type);
  assign accept = (state_q == ST_IDLE) && (op != TLB_OP_NONE) && !bus.flush;
  // Reset or flush in the op cycle kills every write leaving the unit on that edge.
  assign op_ok  = rst && !bus.flush;
  assign arr_we = op_ok && (state_q == ST_WRITE);
  assign rd_we  = op_ok && (state_q == ST_READ);

  always_comb begin
    state_d = state_q;
    ehi_d   = ehi_q;
    lo0_d   = lo0_q;
    lo1_d   = lo1_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ehi_d = bus.cp0_entryhi;
          lo0_d = bus.cp0_entrylo0;
          lo1_d = bus.cp0_entrylo1;
          idx_d = bus.cp0_index[IDXW-1:0];
          unique case (op)
            TLB_OP_TLBP: state_d = ST_PROBE;
            TLB_OP_TLBR: state_d = ST_READ;
            default:     state_d = ST_WRITE;
          endcase
        end
      end
      ST_PROBE, ST_READ, ST_WRITE: state_d = bus.flush ? ST_IDLE : ST_DONE;
      ST_DONE: if (bus.adv || bus.flush) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
    ehi_q <= ehi_d;
    lo0_q <= lo0_d;
    lo1_q <= lo1_d;
    idx_q <= idx_d;
  end

  always_comb begin
    wentry      = '0;
    wentry.vpn2 = ehi_q[31:EHI_VPN2_LSB];
    wentry.asid = ehi_q[ASID_W-1:0];
    wentry.g    = lo0_q[LO_G] & lo1_q[LO_G];
    wentry.pfn0 = lo0_q[LO_PFN_LSB+19:LO_PFN_LSB];
    wentry.c0   = lo0_q[LO_C_LSB+2:LO_C_LSB];
    wentry.d0   = lo0_q[LO_D];
    wentry.v0   = lo0_q[LO_V];
    wentry.pfn1 = lo1_q[LO_PFN_LSB+19:LO_PFN_LSB];
    wentry.c1   = lo1_q[LO_C_LSB+2:LO_C_LSB];
    wentry.d1   = lo1_q[LO_D];
    wentry.v1   = lo1_q[LO_V];
  end

  tlb_array #(.ENTRIES(ENTRIES), .IDXW(IDXW)) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (arr_we),
    .widx    (idx_q),
    .wentry  (wentry),
    .ridx    (idx_q),
    .rentry  (rentry),
    .pr_vpn2 (ehi_q[31:EHI_VPN2_LSB]),
    .pr_asid (ehi_q[ASID_W-1:0]),
    .pr_hit  (pr_hit),
    .pr_idx  (pr_idx),
    .lk_vpn  (bus.lk_vaddr[31:12]),
    .lk_asid (bus.cp0_entryhi[ASID_W-1:0]),
    .lk_hit  (lk_hit),
    .lk_v    (bus.lk_v),
    .lk_d    (bus.lk_d),
    .lk_pfn  (lk_pfn)
  );

  always_comb begin
    bus.stall        = rst && (accept || (state_q inside {ST_PROBE, ST_READ, ST_WRITE}));
    bus.index_we     = op_ok && (state_q == ST_PROBE);
    bus.index_val    = '0;
    if (bus.index_we) bus.index_val = pr_hit ? 32'(pr_idx) : 32'h8000_0000;
    bus.entryhi_we   = rd_we;
    bus.entrylo0_we  = rd_we;
    bus.entrylo1_we  = rd_we;
    bus.entryhi_val  = rd_we ? {rentry.vpn2, 5'b0, rentry.asid} : '0;
    bus.entrylo0_val = rd_we ? {6'b0, rentry.pfn0, rentry.c0, rentry.d0, rentry.v0, rentry.g} : '0;
    bus.entrylo1_val = rd_we ? {6'b0, rentry.pfn1, rentry.c1, rentry.d1, rentry.v1, rentry.g} : '0;
    bus.lk_hit       = lk_hit;
    bus.lk_paddr     = lk_hit ? {lk_pfn, bus.lk_vaddr[11:0]} : '0;
  end

  assign unused_bits = ^{bus.cp0_index[31:IDXW], ehi_q[EHI_VPN2_LSB-1:ASID_W],
                         lo0_q[31:LO_PFN_LSB+20], lo1_q[31:LO_PFN_LSB+20]};

endmodule

// File: tb/tb_tlb_op_unit.sv
// Directed bench for tlb_op_unit: stimulus pushes expected CP0 write pulses into a queue,
// an independent monitor pops and compares whenever a write-enable appears.
module tb_tlb_op_unit;
  import tlb_op_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tlb_op_unit_if bus ();

  tlb_op_unit #(.ENTRIES(16), .IDXW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  we;
    logic [31:0] idx;
    logic [31:0] ehi;
    logic [31:0] lo0;
    logic [31:0] lo1;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] we, input logic [31:0] idx, input logic [31:0] ehi,
                      input logic [31:0] lo0, input logic [31:0] lo1);
    exp_t e;
    e.we = we; e.idx = idx; e.ehi = ehi; e.lo0 = lo0; e.lo1 = lo1;
    sb.push_back(e);
  endtask

  // Monitor: one pop per cycle with any CP0 write-enable asserted.
  initial begin
    exp_t       e;
    logic [3:0] m;
    forever begin
      @(negedge clk);
      m = {bus.index_we, bus.entryhi_we, bus.entrylo0_we, bus.entrylo1_we};
      if (m != 4'b0000) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_we actual=%b required=none", m);
        end else begin
          e = sb.pop_front();
          chk("we_mask", 32'(m), 32'(e.we));
          chk("index_val", bus.index_val, e.idx);
          chk("entryhi_val", bus.entryhi_val, e.ehi);
          chk("entrylo0_val", bus.entrylo0_val, e.lo0);
          chk("entrylo1_val", bus.entrylo1_val, e.lo1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic do_op(input logic [1:0] op, input logic [31:0] ehi, input logic [31:0] lo0,
                       input logic [31:0] lo1, input logic [31:0] idx, input bit fl);
    @(posedge clk); #1;
    bus.tlb_type = op; bus.cp0_entryhi = ehi; bus.cp0_entrylo0 = lo0;
    bus.cp0_entrylo1 = lo1; bus.cp0_index = idx;
    #1 chk("stall_accept", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    chk("stall_op", 32'(bus.stall), 32'd1);
    if (fl) bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.tlb_type = TLB_OP_NONE;
    #1 chk("stall_after", 32'(bus.stall), 32'd0);
  endtask

  task automatic lookup(input logic [31:0] va, input logic [31:0] ehi, input logic hit,
                        input logic v, input logic d, input logic [31:0] pa);
    bus.lk_vaddr = va; bus.cp0_entryhi = ehi;
    #1;
    chk("lk_hit", 32'(bus.lk_hit), 32'(hit));
    chk("lk_v", 32'(bus.lk_v), 32'(v));
    chk("lk_d", 32'(bus.lk_d), 32'(d));
    chk("lk_paddr", bus.lk_paddr, pa);
  endtask

  initial begin
    rst = 1'b0;
    bus.tlb_type = TLB_OP_NONE; bus.flush = 1'b0; bus.adv = 1'b1;
    bus.cp0_entryhi = '0; bus.cp0_entrylo0 = '0; bus.cp0_entrylo1 = '0;
    bus.cp0_index = '0; bus.lk_vaddr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_we", 32'({bus.index_we, bus.entryhi_we, bus.entrylo0_we, bus.entrylo1_we}), 32'd0);
    chk("rst_index_val", bus.index_val, 32'd0);
    chk("rst_entryhi_val", bus.entryhi_val, 32'd0);
    lookup(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;

    // TLBWI index 3, then translate even and odd pages
    do_op(TLB_OP_TLBWI, 32'h0040_2005, 32'h0000_1047, 32'h0000_1087, 32'd3, 1'b0);
    lookup(32'h0040_2ABC, 32'h0000_0005, 1'b1, 1'b1, 1'b1, 32'h0004_1ABC);
    lookup(32'h0040_3123, 32'h0000_0009, 1'b1, 1'b1, 1'b1, 32'h0004_2123);
    lookup(32'h0080_2ABC, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 32'h0);

    // TLBP hit and miss
    push(4'b1000, 32'h0000_0003, 32'h0, 32'h0, 32'h0);
    do_op(TLB_OP_TLBP, 32'h0040_2005, 32'h0, 32'h0, 32'h0, 1'b0);
    push(4'b1000, 32'h8000_0000, 32'h0, 32'h0, 32'h0);
    do_op(TLB_OP_TLBP, 32'h1234_4005, 32'h0, 32'h0, 32'h0, 1'b0);

    // TLBR index 3
    push(4'b0111, 32'h0, 32'h0040_2005, 32'h0000_1047, 32'h0000_1087);
    do_op(TLB_OP_TLBR, 32'h0, 32'h0, 32'h0, 32'd3, 1'b0);

    // ASID match rules: non-global misses on other ASID, global hits
    do_op(TLB_OP_TLBWI, 32'h0080_0005, 32'h0000_1046, 32'h0000_1087, 32'd5, 1'b0);
    push(4'b1000, 32'h8000_0000, 32'h0, 32'h0, 32'h0);
    do_op(TLB_OP_TLBP, 32'h0080_0006, 32'h0, 32'h0, 32'h0, 1'b0);
    do_op(TLB_OP_TLBWI, 32'h0080_0005, 32'h0000_1047, 32'h0000_1087, 32'd5, 1'b0);
    push(4'b1000, 32'h0000_0005, 32'h0, 32'h0, 32'h0);
    do_op(TLB_OP_TLBP, 32'h0080_0006, 32'h0, 32'h0, 32'h0, 1'b0);

    // Flushed TLBWI leaves entry 3 unchanged
    do_op(TLB_OP_TLBWI, 32'h0000_6001, 32'h0000_2007, 32'h0000_2087, 32'd3, 1'b1);
    push(4'b0111, 32'h0, 32'h0040_2005, 32'h0000_1047, 32'h0000_1087);
    do_op(TLB_OP_TLBR, 32'h0, 32'h0, 32'h0, 32'd3, 1'b0);

    // Held in DONE with the same TLBP still presented: one pulse only
    push(4'b1000, 32'h0000_0003, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    bus.adv = 1'b0; bus.tlb_type = TLB_OP_TLBP; bus.cp0_entryhi = 32'h0040_2005;
    #1 chk("hold_stall_accept", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    chk("hold_stall_op", 32'(bus.stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("hold_stall_done", 32'(bus.stall), 32'd0);
    end
    bus.adv = 1'b1;
    @(posedge clk); #1;
    bus.tlb_type = TLB_OP_NONE;
    #1 chk("hold_stall_idle", 32'(bus.stall), 32'd0);

    // Reset during PROBE: no index write, back to IDLE with a cleared array
    @(posedge clk); #1;
    bus.tlb_type = TLB_OP_TLBP; bus.cp0_entryhi = 32'h0040_2005;
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("rst_probe_we", 32'(bus.index_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; bus.tlb_type = TLB_OP_NONE;
    #1 chk("rst_probe_stall", 32'(bus.stall), 32'd0);
    lookup(32'h0040_2ABC, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 32'h0);
    push(4'b1000, 32'h8000_0000, 32'h0, 32'h0, 32'h0);
    do_op(TLB_OP_TLBP, 32'h0040_2005, 32'h0, 32'h0, 32'h0, 1'b0);

    repeat (2) @(posedge clk);
    #1 chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
